// File: rtl/rv_exec_datapath.sv
// rv_exec_datapath: single-cycle RV32I integer execution datapath.
// Decodes R-type and I-type ALU instructions, reads two operands from a
// 32x32 register file, computes the result and writes it back on the same
// clock edge. Alongside it keeps instruction/ALU/register-access counters,
// per-register and per-op usage counters with registered argmax, and a
// registered per-operation power weight.
module rv_exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        validInstruction,
  output logic        completeInstruction,
  output logic [31:0] totalInstructions,
  output logic [31:0] totalOperationsALU,
  output logic [31:0] totalRegAccesses,
  output logic [7:0]  currentEstimatedPower,
  output logic [4:0]  mostUsedReg,
  output logic [3:0]  mostUsedOpsALU,
  output logic [4:0]  rs1Debug,
  output logic [4:0]  rs2Debug,
  output logic [4:0]  rdDebug,
  output logic [31:0] resultALUDebug,
  output logic [31:0] rsData1Debug,
  output logic [31:0] rsData2Debug
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9
  } alu_op_e;

  localparam int          NUM_OPS = 10;
  localparam logic [6:0]  OPC_R   = 7'b0110011;
  localparam logic [6:0]  OPC_I   = 7'b0010011;
  localparam logic [15:0] USE_MAX = 16'hFFFF;

  // Instruction fields
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        f7_zero, f7_alt;

  assign opcode  = instruction[6:0];
  assign rd      = instruction[11:7];
  assign funct3  = instruction[14:12];
  assign rs1     = instruction[19:15];
  assign rs2     = instruction[24:20];
  assign funct7  = instruction[31:25];
  assign imm     = {{20{instruction[31]}}, instruction[31:20]};
  assign f7_zero = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);

  // Decoded control
  alu_op_e dec_op;
  logic    dec_valid;
  logic    is_r;
  logic    execute;

  // Architectural and monitoring state
  logic [31:0] regs_q [32];
  logic [15:0] reg_use_q [32];
  logic [15:0] op_use_q [NUM_OPS];
  logic [31:0] instr_cnt_q, alu_cnt_q, acc_cnt_q;
  logic [31:0] acc_inc_d;
  logic        complete_q;
  logic [7:0]  power_q, power_d;
  logic [4:0]  most_reg_q, most_reg_d;
  logic [3:0]  most_op_q, most_op_d;

  // Datapath
  logic [31:0] rs1_data, rs2_data, operand_b, alu_result;
  logic [4:0]  shamt;

  // Decode the instruction into an ALU op and a validity flag
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case statements can leave it unassigned (latch).
    dec_valid = 1'b0;
    dec_op    = OP_ADD;
    is_r      = 1'b0;
    case (opcode)
      OPC_R: begin
        is_r = 1'b1;
        case (funct3)
          3'b000: begin dec_op = f7_alt ? OP_SUB : OP_ADD; dec_valid = f7_zero | f7_alt; end
          3'b001: begin dec_op = OP_SLL;  dec_valid = f7_zero; end
          3'b010: begin dec_op = OP_SLT;  dec_valid = f7_zero; end
          3'b011: begin dec_op = OP_SLTU; dec_valid = f7_zero; end
          3'b100: begin dec_op = OP_XOR;  dec_valid = f7_zero; end
          3'b101: begin dec_op = f7_alt ? OP_SRA : OP_SRL; dec_valid = f7_zero | f7_alt; end
          3'b110: begin dec_op = OP_OR;   dec_valid = f7_zero; end
          default: begin dec_op = OP_AND; dec_valid = f7_zero; end
        endcase
      end
      OPC_I: begin
        case (funct3)
          3'b000: begin dec_op = OP_ADD;  dec_valid = 1'b1; end
          3'b001: begin dec_op = OP_SLL;  dec_valid = f7_zero; end
          3'b010: begin dec_op = OP_SLT;  dec_valid = 1'b1; end
          3'b011: begin dec_op = OP_SLTU; dec_valid = 1'b1; end
          3'b100: begin dec_op = OP_XOR;  dec_valid = 1'b1; end
          3'b101: begin dec_op = f7_alt ? OP_SRA : OP_SRL; dec_valid = f7_zero | f7_alt; end
          3'b110: begin dec_op = OP_OR;   dec_valid = 1'b1; end
          default: begin dec_op = OP_AND; dec_valid = 1'b1; end
        endcase
      end
      default: ;
    endcase
  end

  assign execute = validInstruction & dec_valid;

  // Register reads are combinational; x0 is hardwired to zero
  assign rs1_data  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_data  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign operand_b = is_r ? rs2_data : imm;
  assign shamt     = operand_b[4:0];

  // ALU
  always_comb begin
    case (dec_op)
      OP_ADD:  alu_result = rs1_data + operand_b;
      OP_SUB:  alu_result = rs1_data - operand_b;
      OP_AND:  alu_result = rs1_data & operand_b;
      OP_OR:   alu_result = rs1_data | operand_b;
      OP_XOR:  alu_result = rs1_data ^ operand_b;
      OP_SLL:  alu_result = rs1_data << shamt;
      OP_SRL:  alu_result = rs1_data >> shamt;
      OP_SRA:  alu_result = $signed(rs1_data) >>> shamt;
      OP_SLT:  alu_result = {31'd0, $signed(rs1_data) < $signed(operand_b)};
      OP_SLTU: alu_result = {31'd0, rs1_data < operand_b};
      default: alu_result = 32'd0;
    endcase
  end

  // Register-file accesses for this instruction: operand reads plus write-back
  assign acc_inc_d = (is_r ? 32'd2 : 32'd1) + {31'd0, rd != 5'd0};

  // Power weight of the operation executing this cycle
  always_comb begin
    power_d = 8'd0;
    if (execute) begin
      case (dec_op)
        OP_ADD:  power_d = 8'd20;
        OP_SUB:  power_d = 8'd22;
        OP_AND:  power_d = 8'd10;
        OP_OR:   power_d = 8'd10;
        OP_XOR:  power_d = 8'd12;
        OP_SLL:  power_d = 8'd30;
        OP_SRL:  power_d = 8'd30;
        OP_SRA:  power_d = 8'd32;
        OP_SLT:  power_d = 8'd16;
        OP_SLTU: power_d = 8'd16;
        default: power_d = 8'd0;
      endcase
    end
  end

  // Argmax of the usage counters; strict '>' keeps the lowest index on ties
  always_comb begin
    logic [15:0] best_reg_cnt, best_op_cnt;
    most_reg_d   = 5'd0;
    best_reg_cnt = reg_use_q[0];
    for (int i = 1; i < 32; i++) begin
      if (reg_use_q[i] > best_reg_cnt) begin
        best_reg_cnt = reg_use_q[i];
        most_reg_d   = 5'(i);
      end
    end
    most_op_d   = 4'd0;
    best_op_cnt = op_use_q[0];
    for (int i = 1; i < NUM_OPS; i++) begin
      if (op_use_q[i] > best_op_cnt) begin
        best_op_cnt = op_use_q[i];
        most_op_d   = 4'(i);
      end
    end
  end

  // Register file write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the array is cleared on reset because x1-x31 are architectural
      // state that must read zero after reset; this rules out plain RAM macros.
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (execute && rd != 5'd0) begin
      // NOTE: state is always updated with non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      regs_q[rd] <= alu_result;
    end
  end

  // Performance counters and saturating usage counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_cnt_q <= 32'd0;
      alu_cnt_q   <= 32'd0;
      acc_cnt_q   <= 32'd0;
      for (int i = 0; i < 32; i++) reg_use_q[i] <= 16'd0;
      for (int i = 0; i < NUM_OPS; i++) op_use_q[i] <= 16'd0;
    end else if (execute) begin
      instr_cnt_q <= instr_cnt_q + 32'd1;
      alu_cnt_q   <= alu_cnt_q + 32'd1;
      acc_cnt_q   <= acc_cnt_q + acc_inc_d;
      if (rd != 5'd0 && reg_use_q[rd] != USE_MAX) reg_use_q[rd] <= reg_use_q[rd] + 16'd1;
      if (op_use_q[dec_op] != USE_MAX) op_use_q[dec_op] <= op_use_q[dec_op] + 16'd1;
    end
  end

  // Registered status: completion pulse, power weight and argmax results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      complete_q <= 1'b0;
      power_q    <= 8'd0;
      most_reg_q <= 5'd0;
      most_op_q  <= 4'd0;
    end else begin
      complete_q <= execute;
      power_q    <= power_d;
      most_reg_q <= most_reg_d;
      most_op_q  <= most_op_d;
    end
  end

  assign completeInstruction   = complete_q;
  assign totalInstructions     = instr_cnt_q;
  assign totalOperationsALU    = alu_cnt_q;
  assign totalRegAccesses      = acc_cnt_q;
  assign currentEstimatedPower = power_q;
  assign mostUsedReg           = most_reg_q;
  assign mostUsedOpsALU        = most_op_q;
  assign rs1Debug              = rs1;
  assign rs2Debug              = rs2;
  assign rdDebug               = rd;
  assign resultALUDebug        = alu_result;
  assign rsData1Debug          = rs1_data;
  assign rsData2Debug          = rs2_data;

endmodule

// File: tb/tb_rv_exec_datapath.sv
// Testbench for rv_exec_datapath: directed RV32I vectors, an architectural
// model of the datapath and monitors, and per-cycle comparison against it.
module tb_rv_exec_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruction = 32'd0;
  logic        validInstruction = 1'b0;
  logic        completeInstruction;
  logic [31:0] totalInstructions, totalOperationsALU, totalRegAccesses;
  logic [7:0]  currentEstimatedPower;
  logic [4:0]  mostUsedReg;
  logic [3:0]  mostUsedOpsALU;
  logic [4:0]  rs1Debug, rs2Debug, rdDebug;
  logic [31:0] resultALUDebug, rsData1Debug, rsData2Debug;

  int checks = 0;
  int errors = 0;

  rv_exec_datapath dut (
    .clk                   (clk),
    .reset                 (reset),
    .instruction           (instruction),
    .validInstruction      (validInstruction),
    .completeInstruction   (completeInstruction),
    .totalInstructions     (totalInstructions),
    .totalOperationsALU    (totalOperationsALU),
    .totalRegAccesses      (totalRegAccesses),
    .currentEstimatedPower (currentEstimatedPower),
    .mostUsedReg           (mostUsedReg),
    .mostUsedOpsALU        (mostUsedOpsALU),
    .rs1Debug              (rs1Debug),
    .rs2Debug              (rs2Debug),
    .rdDebug               (rdDebug),
    .resultALUDebug        (resultALUDebug),
    .rsData1Debug          (rsData1Debug),
    .rsData2Debug          (rsData2Debug)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] m_regs [32];
  int          m_reg_use [32];
  int          m_op_use [10];
  int          m_weight [10] = '{20, 22, 10, 10, 12, 30, 30, 32, 16, 16};
  logic [31:0] m_tot, m_ops, m_acc;
  logic        m_complete;
  logic [7:0]  m_power;
  logic [4:0]  m_most_reg;
  logic [3:0]  m_most_op;

  // Op numbers: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9
  function automatic void m_decode(input logic [31:0] ins, output bit ok, output int op, output bit r);
    logic [6:0] f7;
    logic [2:0] f3;
    f7 = ins[31:25];
    f3 = ins[14:12];
    ok = 1'b0; op = 0; r = 1'b0;
    if (ins[6:0] == 7'h33) begin
      r = 1'b1;
      case ({f7, f3})
        {7'h00, 3'd0}: begin ok = 1; op = 0; end
        {7'h20, 3'd0}: begin ok = 1; op = 1; end
        {7'h00, 3'd1}: begin ok = 1; op = 5; end
        {7'h00, 3'd2}: begin ok = 1; op = 8; end
        {7'h00, 3'd3}: begin ok = 1; op = 9; end
        {7'h00, 3'd4}: begin ok = 1; op = 4; end
        {7'h00, 3'd5}: begin ok = 1; op = 6; end
        {7'h20, 3'd5}: begin ok = 1; op = 7; end
        {7'h00, 3'd6}: begin ok = 1; op = 3; end
        {7'h00, 3'd7}: begin ok = 1; op = 2; end
        default: ok = 0;
      endcase
    end else if (ins[6:0] == 7'h13) begin
      case (f3)
        3'd0: begin ok = 1; op = 0; end
        3'd2: begin ok = 1; op = 8; end
        3'd3: begin ok = 1; op = 9; end
        3'd4: begin ok = 1; op = 4; end
        3'd6: begin ok = 1; op = 3; end
        3'd7: begin ok = 1; op = 2; end
        3'd1: begin ok = (f7 == 7'h00); op = 5; end
        default: begin ok = (f7 == 7'h00) || (f7 == 7'h20); op = (f7 == 7'h20) ? 7 : 6; end
      endcase
    end
  endfunction

  function automatic logic [31:0] m_alu(input int op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return a << sh;
      6: return a >> sh;
      7: return $signed(a) >>> sh;
      8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_operand_b(input logic [31:0] ins, input bit r);
    if (r) return m_regs[ins[24:20]];
    return {{20{ins[31]}}, ins[31:20]};
  endfunction

  // Model state advances on each clock edge; reset clears it immediately
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_reg_use[i] = 0; end
      for (int i = 0; i < 10; i++) m_op_use[i] = 0;
      m_tot = 0; m_ops = 0; m_acc = 0;
      m_complete = 0; m_power = 0; m_most_reg = 0; m_most_op = 0;
    end else begin
      bit ok, r;
      int op, best;
      logic [31:0] res;
      logic [4:0]  rd;
      best = 0;
      for (int i = 1; i < 32; i++) if (m_reg_use[i] > m_reg_use[best]) best = i;
      m_most_reg = 5'(best);
      best = 0;
      for (int i = 1; i < 10; i++) if (m_op_use[i] > m_op_use[best]) best = i;
      m_most_op = 4'(best);
      m_decode(instruction, ok, op, r);
      rd = instruction[11:7];
      if (validInstruction && ok) begin
        res = m_alu(op, m_regs[instruction[19:15]], m_operand_b(instruction, r));
        m_tot = m_tot + 1;
        m_ops = m_ops + 1;
        m_acc = m_acc + (r ? 2 : 1) + ((rd != 0) ? 1 : 0);
        if (rd != 0) begin
          m_regs[rd] = res;
          if (m_reg_use[rd] < 65535) m_reg_use[rd]++;
        end
        if (m_op_use[op] < 65535) m_op_use[op]++;
        m_complete = 1'b1;
        m_power    = 8'(m_weight[op]);
      end else begin
        m_complete = 1'b0;
        m_power    = 8'd0;
      end
    end
  end

  // Compare every DUT output with the model, away from the active edge
  always @(negedge clk) begin
    bit ok, r;
    int op;
    check("completeInstruction", {31'd0, completeInstruction}, {31'd0, m_complete});
    check("totalInstructions", totalInstructions, m_tot);
    check("totalOperationsALU", totalOperationsALU, m_ops);
    check("totalRegAccesses", totalRegAccesses, m_acc);
    check("currentEstimatedPower", {24'd0, currentEstimatedPower}, {24'd0, m_power});
    check("mostUsedReg", {27'd0, mostUsedReg}, {27'd0, m_most_reg});
    check("mostUsedOpsALU", {28'd0, mostUsedOpsALU}, {28'd0, m_most_op});
    check("rs1Debug", {27'd0, rs1Debug}, {27'd0, instruction[19:15]});
    check("rs2Debug", {27'd0, rs2Debug}, {27'd0, instruction[24:20]});
    check("rdDebug", {27'd0, rdDebug}, {27'd0, instruction[11:7]});
    check("rsData1Debug", rsData1Debug, m_regs[instruction[19:15]]);
    check("rsData2Debug", rsData2Debug, m_regs[instruction[24:20]]);
    m_decode(instruction, ok, op, r);
    if (ok)
      check("resultALUDebug", resultALUDebug,
            m_alu(op, m_regs[instruction[19:15]], m_operand_b(instruction, r)));
  end

  // ---------------- stimulus ----------------
  task automatic present(input logic [31:0] ins, input logic v);
    @(negedge clk);
    #2;
    instruction      = ins;
    validInstruction = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exec(input logic [31:0] ins);
    present(ins, 1'b1);
    tick();
  endtask

  // Assorted ALU vectors, checked against the model
  logic [31:0] alu_vectors [12] = '{
    32'hFFF24393,  // xori  x7,x4,-1    -> 1
    32'h40125413,  // srai  x8,x4,1     -> 0xFFFFFFFF
    32'h00425493,  // srli  x9,x4,4     -> 0x0FFFFFFF
    32'h00122533,  // slt   x10,x4,x1   -> 1
    32'h001235B3,  // sltu  x11,x4,x1   -> 0
    32'h00209633,  // sll   x12,x1,x2   -> 640
    32'h0020F6B3,  // and   x13,x1,x2   -> 5
    32'h0020E733,  // or    x14,x1,x2   -> 7
    32'hFFF0B793,  // sltiu x15,x1,-1   -> 1
    32'h022081B3,  // funct7 0000001    -> not executed
    32'h40109093,  // slli with funct7 0100000 -> not executed
    32'h00F0C813   // xori x16,x1,15    -> 10
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    #2;
    check("reset totalInstructions", totalInstructions, 32'd0);
    check("reset completeInstruction", {31'd0, completeInstruction}, 32'd0);
    check("reset currentEstimatedPower", {24'd0, currentEstimatedPower}, 32'd0);
    check("reset mostUsedReg", {27'd0, mostUsedReg}, 32'd0);
    check("reset mostUsedOpsALU", {28'd0, mostUsedOpsALU}, 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // addi x1,x0,5
    exec(32'h00500093);
    check("addi x1 complete", {31'd0, completeInstruction}, 32'd1);
    check("addi x1 totalInstructions", totalInstructions, 32'd1);
    check("addi x1 totalRegAccesses", totalRegAccesses, 32'd2);
    check("addi x1 power", {24'd0, currentEstimatedPower}, 32'd20);

    exec(32'h00700113);                       // addi x2,x0,7
    present(32'h002081B3, 1'b1);              // add x3,x1,x2
    #1;
    check("x1 readback", rsData1Debug, 32'd5);
    check("x2 readback", rsData2Debug, 32'd7);
    check("add result", resultALUDebug, 32'd12);
    tick();
    present(32'h40208233, 1'b1);              // sub x4,x1,x2
    #1;
    check("sub result", resultALUDebug, 32'hFFFFFFFE);
    check("sub power pending add", {24'd0, currentEstimatedPower}, 32'd20);
    tick();
    check("sub power", {24'd0, currentEstimatedPower}, 32'd22);
    check("four executed", totalInstructions, 32'd4);
    check("accesses after four", totalRegAccesses, 32'd10);

    // Idle cycle reading x3/x4
    present(32'h00418033, 1'b0);
    #1;
    check("x3 readback", rsData1Debug, 32'd12);
    check("x4 readback", rsData2Debug, 32'hFFFFFFFE);
    tick();
    check("idle complete", {31'd0, completeInstruction}, 32'd0);
    check("idle power", {24'd0, currentEstimatedPower}, 32'd0);
    check("idle totalInstructions", totalInstructions, 32'd4);

    // add x0,x1,x2: accesses +2, x0 stays zero
    exec(32'h00208033);
    check("add x0 accesses", totalRegAccesses, 32'd12);
    check("add x0 totalInstructions", totalInstructions, 32'd5);
    present(32'h00000033, 1'b0);
    #1;
    check("x0 reads zero", rsData1Debug, 32'd0);

    // Invalid opcode with valid=1
    exec(32'h0000007F);
    check("invalid complete", {31'd0, completeInstruction}, 32'd0);
    check("invalid power", {24'd0, currentEstimatedPower}, 32'd0);
    check("invalid totalInstructions", totalInstructions, 32'd5);
    check("invalid accesses", totalRegAccesses, 32'd12);

    // Tie between x5 and x6 (two writes each) must report x5
    exec(32'h00100293);                       // addi x5,x0,1
    exec(32'h00100313);                       // addi x6,x0,1
    exec(32'h00100293);
    exec(32'h00100313);
    present(32'h00000000, 1'b0);
    tick();
    check("tie mostUsedReg", {27'd0, mostUsedReg}, 32'd5);
    exec(32'h00100293);                       // x5 third write
    tick();
    check("x5 mostUsedReg", {27'd0, mostUsedReg}, 32'd5);
    check("add dominant op", {28'd0, mostUsedOpsALU}, 32'd0);

    foreach (alu_vectors[i]) exec(alu_vectors[i]);
    present(32'h00100293, 1'b0);
    tick();

    // Mid-stream asynchronous reset, between clock edges
    present(32'h00128833, 1'b1);              // add x16,x5,x1
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async totalInstructions", totalInstructions, 32'd0);
    check("async totalRegAccesses", totalRegAccesses, 32'd0);
    check("async totalOperationsALU", totalOperationsALU, 32'd0);
    check("async complete", {31'd0, completeInstruction}, 32'd0);
    check("async power", {24'd0, currentEstimatedPower}, 32'd0);
    check("async mostUsedReg", {27'd0, mostUsedReg}, 32'd0);
    check("async mostUsedOpsALU", {28'd0, mostUsedOpsALU}, 32'd0);
    check("async x5 cleared", rsData1Debug, 32'd0);
    check("async x1 cleared", rsData2Debug, 32'd0);
    tick();
    @(negedge clk);
    #2;
    reset            = 1'b0;
    instruction      = 32'h00500093;          // addi x1,x0,5 on first edge after reset
    validInstruction = 1'b1;
    tick();
    check("post-reset first edge executes", totalInstructions, 32'd1);
    present(32'h00080033, 1'b0);              // reads x16
    #1;
    check("cancelled write x16", rsData1Debug, 32'd0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_exec_datapath.md
# rv_exec_datapath

Single-cycle RV32I integer execution datapath: instruction decoder, 32×32 register file and ALU, plus performance and power monitoring. It sits behind the instruction-fetch stage. Each presented instruction is decoded and its operands read, computed and written back on one clock edge. It also keeps running counters of instructions, ALU operations and register accesses, and reports a per-operation power estimate.

## Interface
No parameters.
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- instruction  input  32  RV32I instruction word
- validInstruction  input  1  instruction is present this cycle
- completeInstruction  output  1  one-cycle pulse: an instruction was executed on the previous edge
- totalInstructions  output  32  executed-instruction count
- totalOperationsALU  output  32  ALU operation count
- totalRegAccesses  output  32  register-file access count
- currentEstimatedPower  output  8  power weight of last cycle's operation
- mostUsedReg  output  5  most-written destination register
- mostUsedOpsALU  output  4  most-used ALU op code
- rs1Debug, rs2Debug, rdDebug  output  5 each  instruction fields [19:15], [24:20], [11:7]
- resultALUDebug  output  32  current combinational ALU result
- rsData1Debug, rsData2Debug  output  32 each  current register read data

## Operation
- Decode:
  - R-type (opcode 0110011): ADD, SUB (funct7 0100000), SLL, SLT, SLTU, XOR, SRL, SRA (funct7 0100000), OR, AND.
  - I-type (opcode 0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - Immediates are sign-extended [31:20]; shift amount is [24:20].
  - Any other opcode, or any other funct7 for R-type or shifts, is not valid and is not executed.
- ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9.
- ALU behaviour:
  - Combinational. Operand A is rs1 data; operand B is rs2 data (R-type) or the immediate (I-type).
  - Arithmetic wraps modulo 2^32. Shifts use B[4:0]. SLT/SLTU return 1 or 0.
- Register file:
  - Reads are combinational.
  - x0 always reads 0; writes to x0 are discarded.
- Execute condition: validInstruction and the instruction decodes as valid. On that rising edge:
  - rd ← ALU result.
  - totalInstructions and totalOperationsALU each +1.
  - totalRegAccesses increases by 2 for R-type, 1 for I-type, plus 1 more if rd≠0.
  - The 16-bit saturating usage counter of rd is incremented (rd≠0 only).
  - The 16-bit saturating counter of the op is incremented.
- No instruction executes when the condition is false. Counters, registers and the usage counters hold; completeInstruction falls to 0.
- mostUsedReg and mostUsedOpsALU are registered argmax values of the usage counters, updated every cycle. Ties resolve to the lowest index. Both are 0 while all counts are 0.
- currentEstimatedPower is registered:
  - On an execute edge it takes the op weight: ADD 20, SUB 22, AND 10, OR 10, XOR 12, SLL 30, SRL 30, SRA 32, SLT 16, SLTU 16.
  - Otherwise it is 0.
- The 32-bit counters wrap.

## Timing
- Reset (asynchronous, takes effect immediately):
  - All registers x1–x31 = 0.
  - All counters and usage counters = 0.
  - completeInstruction = 0, currentEstimatedPower = 0, mostUsedReg = 0, mostUsedOpsALU = 0.
- Debug and result outputs are combinational from the current instruction and register contents.
- Latency: write-back and counter update occur on the same edge that samples the instruction. completeInstruction is high for the following cycle.
- Back-to-back instructions: each cycle, an instruction reads values written at the previous edge. There is no hazard or stall.
- Reset asserted mid-stream cancels any in-flight write. The first edge after reset deasserts may execute.
- argmax outputs lag usage counters by one cycle.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) valid:
  - Required after the edge: x1=5, completeInstruction=1 for one cycle, totalInstructions=1, totalRegAccesses=2, currentEstimatedPower=20.
- Then addi x2,x0,7 (0x00700113), add x3,x1,x2 (0x002081B3), sub x4,x1,x2 (0x40208233):
  - Required during execution: resultALUDebug = 12 for the add and 0xFFFFFFFE for the sub.
  - Required after execution: x3=12, x4=0xFFFFFFFE, totalInstructions=4.
- add x0,x1,x2 (0x00208033):
  - Required: x0 still reads 0, totalRegAccesses +2, no usage increment for x0.
- Hold validInstruction=0 with any instruction, and separately present an invalid opcode 0x0000007F with valid=1:
  - Required in both cases: no register or counter change, completeInstruction=0, currentEstimatedPower=0.
- Write x5 three times and x6 once:
  - Required: mostUsedReg=5.
  - Required: mostUsedOpsALU=0 when ADD/ADDI dominates.
  - Tie check: a tie between x5 and x6 reports 5.
- Assert reset asynchronously mid-stream:
  - Required: all outputs return to reset values immediately, without waiting for a clock edge.
